// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider FSM states, default operand
// width and a constant-evaluable ceiling log2 for sizing counters.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int ARITH_WIDTH = 32;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not borrow.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  // One extra bit so the shifted remainder never overflows the compare;
  // the MSB of the difference is the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, dbit};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[WIDTH];
    rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both
// sides. Define DIV_SIGNED_EN for two's-complement operands and results.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] a_mag, b_mag, q_raw, q_fix, r_fix, step_rem;
  logic             step_q;

`ifdef DIV_SIGNED_EN
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_reg),
    .dbit    (dvd_reg[WIDTH-1]),
    .divisor (dsr_reg),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  // Quotient bits are shifted into the dividend register as it drains.
  assign q_raw = {dvd_reg[WIDTH-2:0], step_q};

  always_comb begin
`ifdef DIV_SIGNED_EN
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fix = neg_q_reg ? -q_raw    : q_raw;
    r_fix = neg_r_reg ? -step_rem : step_rem;
`else
    a_mag = dividend;
    b_mag = divisor;
    q_fix = q_raw;
    r_fix = step_rem;
`endif
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    dvd_next       = dvd_reg;
    dsr_next       = dsr_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
`ifdef DIV_SIGNED_EN
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
          end else begin
            state_next = CALC;
            cnt_next   = '0;
            rem_next   = '0;
            dvd_next   = a_mag;
            dsr_next   = b_mag;
            dbz_next   = 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_next = dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        rem_next = step_rem;
        dvd_next = q_raw;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_STEP) begin
          state_next     = DONE;
          quotient_next  = q_fix;
          remainder_next = r_fix;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      dvd_reg       <= dvd_next;
      dsr_reg       <= dsr_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
`ifdef DIV_SIGNED_EN
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
`endif
    end
  end

  assign in_ready    = (state_reg == IDLE) & ~rst;
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); follows DIV_SIGNED_EN
// when the same macro is defined for the bench.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Presents operands while idle, lets one edge accept them, then returns the
  // number of further edges until out_valid is seen (bounded at 100).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    compared++; if (quotient !== 32'h0) begin mismatched++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL reset_remainder got=%h want=0", remainder); end
    compared++; if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL reset_dbz got=%0b want=0", div_by_zero); end
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_in_ready got=%0b want=1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_op(32'd100, 32'd7, lat);
    $display("basic: 100/7 lat=%0d q=%0d r=%0d dbz=%0b", lat, quotient, remainder, div_by_zero);
    compared++; if (lat !== 32) begin mismatched++; $display("FAIL basic_latency got=%0d want=32", lat); end
    compared++; if (quotient !== 32'd14) begin mismatched++; $display("FAIL basic_quotient got=%0d want=14", quotient); end
    compared++; if (remainder !== 32'd2) begin mismatched++; $display("FAIL basic_remainder got=%0d want=2", remainder); end
    compared++; if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL basic_dbz got=%0b want=0", div_by_zero); end
    @(posedge clk);
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_in_ready_after got=%0b want=1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_out_valid_after got=%0b want=0", out_valid); end
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(32'h1234_5678, 32'h0, lat);
    $display("div_zero: 12345678/0 lat=%0d q=%h r=%h dbz=%0b", lat, quotient, remainder, div_by_zero);
    // DONE is entered on the accept edge itself: out_valid in the first cycle after accept.
    compared++; if (lat !== 0) begin mismatched++; $display("FAIL dbz_latency got=%0d edges want=0 edges after accept", lat); end
    compared++; if (quotient !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL dbz_quotient got=%h want=ffffffff", quotient); end
    compared++; if (remainder !== 32'h1234_5678) begin mismatched++; $display("FAIL dbz_remainder got=%h want=12345678", remainder); end
    compared++; if (div_by_zero !== 1'b1) begin mismatched++; $display("FAIL dbz_flag got=%0b want=1", div_by_zero); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    start_op(32'hFFFF_FFFF, 32'd1, lat);
    $display("stall: ffffffff/1 lat=%0d q=%h r=%h", lat, quotient, remainder);
    compared++; if (lat !== 32) begin mismatched++; $display("FAIL stall_latency got=%0d want=32", lat); end
    dividend = 32'd2;
    divisor  = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      $display("stall: cycle %0d out_valid=%0b in_ready=%0b q=%h r=%h", i, out_valid, in_ready, quotient, remainder);
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stall_out_valid[%0d] got=%0b want=1", i, out_valid); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready[%0d] got=%0b want=0", i, in_ready); end
      compared++; if (quotient !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL stall_quotient[%0d] got=%h want=ffffffff", i, quotient); end
      compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL stall_remainder[%0d] got=%h want=0", i, remainder); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_release_out_valid got=%0b want=0", out_valid); end
    @(posedge clk);
    #1;
    // Operands offered during the stall must not have started a new operation.
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stall_ignored_in_valid in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    dividend = 32'hFFFF_FFF9;
    divisor  = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    $display("reset_mid: rst asserted out_valid=%0b in_ready=%0b q=%h r=%h", out_valid, in_ready, quotient, remainder);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_out_valid got=%0b want=0", out_valid); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rmid_in_ready got=%0b want=0", in_ready); end
    compared++; if (quotient !== 32'h0) begin mismatched++; $display("FAIL rmid_quotient got=%h want=0", quotient); end
    compared++; if (remainder !== 32'h0) begin mismatched++; $display("FAIL rmid_remainder got=%h want=0", remainder); end
    compared++; if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL rmid_dbz got=%0b want=0", div_by_zero); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_release_in_ready got=%0b want=1", in_ready); end
    start_op(32'd9, 32'd3, lat);
    $display("reset_mid: 9/3 lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    compared++; if (lat !== 32) begin mismatched++; $display("FAIL rmid_latency got=%0d want=32", lat); end
    compared++; if (quotient !== 32'd3) begin mismatched++; $display("FAIL rmid_quotient_new got=%0d want=3", quotient); end
    compared++; if (remainder !== 32'd0) begin mismatched++; $display("FAIL rmid_remainder_new got=%0d want=0", remainder); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_signedness();
    int lat;
    logic [31:0] exp_q1, exp_r1, exp_q2, exp_r2;
`ifdef DIV_SIGNED_EN
    exp_q1 = 32'hFFFF_FFFD;  // -7 / 2 = -3
    exp_r1 = 32'hFFFF_FFFF;  // remainder -1
    exp_q2 = 32'h8000_0000;  // MIN / -1 wraps to MIN
    exp_r2 = 32'h0;
`else
    exp_q1 = 32'h7FFF_FFFC;  // 4294967289 / 2
    exp_r1 = 32'd1;
    exp_q2 = 32'h0;          // 0x80000000 / 0xFFFFFFFF
    exp_r2 = 32'h8000_0000;
`endif
    start_op(32'hFFFF_FFF9, 32'd2, lat);
    $display("sign: fffffff9/2 lat=%0d q=%h r=%h", lat, quotient, remainder);
    compared++; if (lat !== 32) begin mismatched++; $display("FAIL sign1_latency got=%0d want=32", lat); end
    compared++; if (quotient !== exp_q1) begin mismatched++; $display("FAIL sign1_quotient got=%h want=%h", quotient, exp_q1); end
    compared++; if (remainder !== exp_r1) begin mismatched++; $display("FAIL sign1_remainder got=%h want=%h", remainder, exp_r1); end
    @(posedge clk);
    #1;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
    $display("sign: 80000000/ffffffff lat=%0d q=%h r=%h", lat, quotient, remainder);
    compared++; if (lat !== 32) begin mismatched++; $display("FAIL sign2_latency got=%0d want=32", lat); end
    compared++; if (quotient !== exp_q2) begin mismatched++; $display("FAIL sign2_quotient got=%h want=%h", quotient, exp_q2); end
    compared++; if (remainder !== exp_r2) begin mismatched++; $display("FAIL sign2_remainder got=%h want=%h", remainder, exp_r2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int t0, t1, n;
    bit seen;
    out_ready = 1'b1;
    dividend  = 32'd20;
    divisor   = 32'd6;
    in_valid  = 1'b1;
    t0 = cyc;
    t1 = -1;
    seen = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        compared++; if (quotient !== 32'd3) begin mismatched++; $display("FAIL b2b_quotient got=%0d want=3", quotient); end
        compared++; if (remainder !== 32'd2) begin mismatched++; $display("FAIL b2b_remainder got=%0d want=2", remainder); end
      end
      if (in_ready) begin
        t1 = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    $display("back_to_back: accept-to-accept period=%0d", t1 - t0);
    compared++; if (t1 - t0 !== 34) begin mismatched++; $display("FAIL b2b_period got=%0d want=34", t1 - t0); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_signedness();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
